// File: rtl/js_phase_decoder.sv
// Johnson-code phase decoder: validates and decodes each sampled Johnson
// state, tracks sequence continuity and locks after LOCK_CNT in-order samples.
module js_phase_decoder #(
    parameter int DATA_WID = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_WID  = 8,
    localparam int PH_WID  = $clog2(2 * DATA_WID)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_WID-1:0] js_data,
    input  logic                js_valid,
    input  logic                err_clr,
    output logic [PH_WID-1:0]   phase,
    output logic                phase_vld,
    output logic                illegal,
    output logic                seq_err,
    output logic                locked,
    output logic [ERR_WID-1:0]  err_cnt
);

    localparam int                 TWO_N    = 2 * DATA_WID;
    localparam logic [PH_WID-1:0]  PH_LAST  = PH_WID'(TWO_N - 1);
    localparam logic [3:0]         RUN_LOCK = 4'(LOCK_CNT);
    localparam logic [ERR_WID-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {UNLOCK, ACQ, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [3:0]          run_q, run_d;
    logic [PH_WID-1:0]   exp_q, exp_d;
    logic [PH_WID-1:0]   phase_q, phase_d;
    logic                vld_q, vld_d;
    logic                ill_q, ill_d;
    logic                seq_q, seq_d;
    logic [ERR_WID-1:0]  err_q, err_d;

    logic                code_legal;
    logic                in_seq;
    logic                err_inc;
    logic [PH_WID-1:0]   ph_dec;
    logic [PH_WID-1:0]   ph_next;
    int                  n_trans;
    int                  n_ones;

    // A Johnson state has at most one boundary between its run of ones and zeros.
    always_comb begin
        n_trans = 0;
        n_ones  = 0;
        for (int i = 0; i < DATA_WID - 1; i++) begin
            if (js_data[i] != js_data[i+1]) n_trans++;
        end
        for (int i = 0; i < DATA_WID; i++) begin
            if (js_data[i]) n_ones++;
        end
        code_legal = (n_trans <= 1);
        ph_dec     = js_data[DATA_WID-1] ? PH_WID'(TWO_N - n_ones) : PH_WID'(n_ones);
        ph_next    = (ph_dec == PH_LAST) ? '0 : ph_dec + PH_WID'(1);
        in_seq     = code_legal && (ph_dec == exp_q);
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        exp_d   = exp_q;
        phase_d = phase_q;
        vld_d   = js_valid;
        ill_d   = ill_q;
        seq_d   = seq_q;
        err_inc = 1'b0;
        if (js_valid) begin
            phase_d = code_legal ? ph_dec : '0;
            ill_d   = !code_legal;
            seq_d   = (state_q == LOCKED) && code_legal && !in_seq;
            if (code_legal) exp_d = ph_next;
            case (state_q)
                UNLOCK: begin
                    if (code_legal) begin
                        state_d = ACQ;
                        run_d   = 4'd1;
                    end
                end
                ACQ: begin
                    if (!code_legal) begin
                        state_d = UNLOCK;
                        run_d   = 4'd0;
                    end else if (in_seq) begin
                        run_d = run_q + 4'd1;
                        if (run_d == RUN_LOCK) state_d = LOCKED;
                    end else begin
                        run_d = 4'd1;
                    end
                end
                LOCKED: begin
                    if (!in_seq) begin
                        state_d = UNLOCK;
                        run_d   = 4'd0;
                        err_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = UNLOCK;
                    run_d   = 4'd0;
                end
            endcase
        end

        // A clear coinciding with a new error keeps that error counted.
        if (err_clr)                          err_d = err_inc ? ERR_WID'(1) : '0;
        else if (err_inc && err_q != ERR_MAX) err_d = err_q + ERR_WID'(1);
        else                                  err_d = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCK;
            run_q   <= '0;
            exp_q   <= '0;
            phase_q <= '0;
            vld_q   <= 1'b0;
            ill_q   <= 1'b0;
            seq_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            exp_q   <= exp_d;
            phase_q <= phase_d;
            vld_q   <= vld_d;
            ill_q   <= ill_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
        end
    end

    assign phase     = phase_q;
    assign phase_vld = vld_q;
    assign illegal   = ill_q;
    assign seq_err   = seq_q;
    assign locked    = (state_q == LOCKED);
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_js_phase_decoder.sv
// Bench for js_phase_decoder: directed scenarios plus random traffic, checked
// against a table-driven reference model; a second instance uses ERR_WID=2.
module tb_js_phase_decoder;

    localparam int N     = 8;
    localparam int LCK   = 4;
    localparam int TWO_N = 2 * N;

    logic       clk = 1'b0;
    logic       rst, js_valid, err_clr;
    logic [7:0] js_data;

    logic [3:0] phase_a, phase_b;
    logic       vld_a, vld_b, ill_a, ill_b, seq_a, seq_b, lck_a, lck_b;
    logic [7:0] err_a;
    logic [1:0] err_b;

    always #5 clk = ~clk;

    js_phase_decoder #(.DATA_WID(N), .LOCK_CNT(LCK), .ERR_WID(8)) u_dut (
        .clk(clk), .rst(rst), .js_data(js_data), .js_valid(js_valid), .err_clr(err_clr),
        .phase(phase_a), .phase_vld(vld_a), .illegal(ill_a), .seq_err(seq_a),
        .locked(lck_a), .err_cnt(err_a)
    );

    js_phase_decoder #(.DATA_WID(N), .LOCK_CNT(LCK), .ERR_WID(2)) u_dut_e2 (
        .clk(clk), .rst(rst), .js_data(js_data), .js_valid(js_valid), .err_clr(err_clr),
        .phase(phase_b), .phase_vld(vld_b), .illegal(ill_b), .seq_err(seq_b),
        .locked(lck_b), .err_cnt(err_b)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: length of current in-order streak and lock flag.
    logic [7:0] jtab [TWO_N];
    int  m_run, m_exp, m_phase, m_err8, m_err2;
    bit  m_locked, m_vld, m_ill, m_seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] jc(input int p);
        return jtab[p % TWO_N];
    endfunction

    task automatic model_update(input bit r, input bit v, input logic [7:0] d, input bit c);
        int  p;
        bit  legal, inc;
        if (r) begin
            m_run = 0; m_exp = 0; m_phase = 0; m_err8 = 0; m_err2 = 0;
            m_locked = 0; m_vld = 0; m_ill = 0; m_seq = 0;
            return;
        end
        m_vld = v;
        inc   = 0;
        if (v) begin
            legal = 0;
            p     = 0;
            for (int k = 0; k < TWO_N; k++) begin
                if (jtab[k] == d) begin
                    legal = 1;
                    p     = k;
                end
            end
            if (!legal) begin
                m_ill = 1; m_seq = 0; m_phase = 0;
                inc = m_locked;
                m_locked = 0; m_run = 0;
            end else begin
                m_ill   = 0;
                m_phase = p;
                m_seq   = m_locked && (p != m_exp);
                if (m_locked) begin
                    if (p != m_exp) begin
                        inc = 1; m_locked = 0; m_run = 0;
                    end
                end else begin
                    if (m_run > 0 && p == m_exp) m_run++;
                    else m_run = 1;
                    if (m_run >= LCK) m_locked = 1;
                end
                m_exp = (p + 1) % TWO_N;
            end
        end
        if (c) begin
            m_err8 = inc ? 1 : 0;
            m_err2 = inc ? 1 : 0;
        end else if (inc) begin
            m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
            m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
        end
    endtask

    task automatic compare_all();
        chk("phase_vld", 32'(vld_a), 32'(m_vld));
        chk("phase_vld_e2", 32'(vld_b), 32'(m_vld));
        chk("locked", 32'(lck_a), 32'(m_locked));
        chk("locked_e2", 32'(lck_b), 32'(m_locked));
        chk("err_cnt", 32'(err_a), 32'(m_err8));
        chk("err_cnt_e2", 32'(err_b), 32'(m_err2));
        chk("seq_ill_excl", 32'(seq_a & ill_a), 32'd0);
        if (m_vld) begin
            chk("phase", 32'(phase_a), 32'(m_phase));
            chk("phase_e2", 32'(phase_b), 32'(m_phase));
            chk("illegal", 32'(ill_a), 32'(m_ill));
            chk("seq_err", 32'(seq_a), 32'(m_seq));
            chk("seq_err_e2", 32'(seq_b), 32'(m_seq));
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d, input bit c);
        rst = r; js_valid = v; js_data = d; err_clr = c;
        @(posedge clk);
        model_update(r, v, d, c);
        #1;
        compare_all();
    endtask

    task automatic feed(input int p);
        step(0, 1, jc(p), 0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_phase"}, 32'(phase_a), 32'd0);
        chk({tag, "_vld"}, 32'(vld_a), 32'd0);
        chk({tag, "_ill"}, 32'(ill_a), 32'd0);
        chk({tag, "_seq"}, 32'(seq_a), 32'd0);
        chk({tag, "_lck"}, 32'(lck_a), 32'd0);
        chk({tag, "_err"}, 32'(err_a), 32'd0);
    endtask

    initial begin
        int cur;
        // Johnson states in phase order: fill ones from the LSB, then clear them.
        for (int p = 0; p < TWO_N; p++) begin
            if (p <= N) jtab[p] = 8'((1 << p) - 1);
            else        jtab[p] = 8'hFF & ~8'((1 << (p - N)) - 1);
        end
        rst = 1; js_valid = 0; js_data = '0; err_clr = 0;
        model_update(1, 0, '0, 0);

        step(1, 1, 8'h3C, 1);
        step(1, 0, 8'h00, 0);
        check_reset_outs("reset");

        // Full sequence through wrap
        for (int i = 0; i <= TWO_N; i++) begin
            feed(i);
            if (i == LCK - 1) chk("lock_after_4th", 32'(lck_a), 32'd1);
        end
        chk("wrap_phase0", 32'(phase_a), 32'd0);

        // Illegal code while locked, then reacquire from 0x07
        step(0, 1, 8'h3C, 0);
        chk("ill_flag", 32'(ill_a), 32'd1);
        chk("ill_phase0", 32'(phase_a), 32'd0);
        chk("ill_unlock", 32'(lck_a), 32'd0);
        chk("ill_err1", 32'(err_a), 32'd1);
        for (int i = 3; i < 3 + LCK; i++) feed(i);
        chk("reacq_lock", 32'(lck_a), 32'd1);

        // Skip from phase 5 to phase 8 while locked
        for (int i = 3 + LCK; i <= TWO_N + 5; i++) feed(i);
        chk("pre_skip_lock", 32'(lck_a), 32'd1);
        step(0, 1, 8'hFF, 0);
        chk("skip_seq", 32'(seq_a), 32'd1);
        chk("skip_ill", 32'(ill_a), 32'd0);
        chk("skip_unlock", 32'(lck_a), 32'd0);
        chk("skip_err2", 32'(err_a), 32'd2);

        // Stall across the 15 -> 0 wrap
        for (int i = 11; i <= 15; i++) feed(i);
        chk("stall_p15", 32'(phase_a), 32'd15);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'h55, 0);
            chk("stall_novld", 32'(vld_a), 32'd0);
        end
        feed(0);
        chk("stall_p0", 32'(phase_a), 32'd0);
        chk("stall_noseq", 32'(seq_a), 32'd0);
        chk("stall_locked", 32'(lck_a), 32'd1);

        // Saturation and clear
        for (int e = 0; e < 5; e++) begin
            for (int i = 0; i < LCK; i++) feed(i);
            step(0, 1, 8'h3C, 0);
        end
        chk("sat_e2", 32'(err_b), 32'd3);
        for (int i = 0; i < LCK; i++) feed(i);
        step(0, 1, 8'h3C, 1);
        chk("clr_inc_e2", 32'(err_b), 32'd1);
        chk("clr_inc", 32'(err_a), 32'd1);
        step(0, 0, 8'h00, 1);
        chk("clr_only", 32'(err_a), 32'd0);

        // Reset while locked
        for (int i = 0; i < LCK; i++) feed(i);
        chk("pre_rst_lock", 32'(lck_a), 32'd1);
        step(1, 1, 8'h0F, 0);
        check_reset_outs("rst_lck");
        step(0, 1, 8'h03, 0);
        chk("post_rst_p2", 32'(phase_a), 32'd2);
        chk("post_rst_acq", 32'(lck_a), 32'd0);

        // Random traffic
        cur = 3;
        for (int n = 0; n < 3000; n++) begin
            int   sel;
            bit   clr;
            logic [7:0] d;
            sel = int'($urandom_range(999));
            clr = ($urandom_range(99) < 3);
            if (sel < 3) begin
                step(1, 1, 8'($urandom), clr);
            end else if (sel < 150) begin
                step(0, 0, 8'($urandom), clr);
            end else begin
                if (sel < 850)      d = jc(cur);
                else if (sel < 930) d = jc(int'($urandom_range(TWO_N - 1)));
                else                d = 8'($urandom);
                step(0, 1, d, clr);
                if (!m_ill) cur = m_phase + 1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
